dmem_port: RTL and testbench

//  MEM-stage data-memory responder. Consumes memwritem/memtoregm/aluoutm/writedatam from the EX/MEM

---
 rtl/dmem_port.sv | 134 +++++++++++++
 tb/tb_dmem_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port.sv
// MEM-stage data-memory port: one req/ack bus transaction per load/store,
// stalls IF..MEM until done. Optional DMEM_TIMEOUT_EN adds a BUSY timeout.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   memwritem, memtoregm       store / load request (both => store)
//   aluoutm, writedatam        byte address, store data
//   readdatam                  last completed load data
//   stallm                     freeze pipeline (combinational)
//   misalignm                  1-cycle pulse, misaligned access dropped
//   mem_req/we/addr/wdata      registered bus request (word address)
//   mem_ack, mem_rdata         bus completion and read data
//   bus_err                    1-cycle pulse on timeout abort
//
// Macro DMEM_TIMEOUT_EN: abort after TIMEOUT_CYCLES BUSY cycles without
// mem_ack. Undefined: BUSY waits forever, bus_err tied low.
module dmem_port #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwritem,
  input  logic              memtoregm,
  input  logic [31:0]       aluoutm,
  input  logic [31:0]       writedatam,
  output logic [31:0]       readdatam,
  output logic              stallm,
  output logic              misalignm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state;

  logic acc;
  logic aligned;

  assign acc     = memwritem | memtoregm;
  assign aligned = (aluoutm[1:0] == 2'b00);

  // DONE is the single cycle in which EX/MEM is allowed to advance.
  assign stallm = acc & (state != S_DONE);

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          expire;

  // Counter value k means k+1 BUSY cycles have elapsed this edge.
  assign expire = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      readdatam <= '0;
      misalignm <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      bus_err   <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      misalignm <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      bus_err   <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (acc) begin
            if (aligned) begin
              mem_req   <= 1'b1;
              mem_we    <= memwritem;
              mem_addr  <= aluoutm[ADDR_W-1:2];
              mem_wdata <= writedatam;
              state     <= S_BUSY;
`ifdef DMEM_TIMEOUT_EN
              cnt       <= '0;
`endif
            end else begin
              misalignm <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          // Ack wins over a timeout on the same edge.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we)
              readdatam <= mem_rdata;
            state <= S_DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (expire) begin
            mem_req <= 1'b0;
            if (!mem_we)
              readdatam <= '0;
            bus_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
// Directed self-checking bench for dmem_port.
// Inputs change on the falling edge, outputs checked 1ns later.
module tb_dmem_port;

`ifdef DMEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk;
  logic        reset;
  logic        memwritem;
  logic        memtoregm;
  logic [31:0] aluoutm;
  logic [31:0] writedatam;
  logic [31:0] readdatam;
  logic        stallm;
  logic        misalignm;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int n_chk;
  int n_err;

  dmem_port #(
    .ADDR_W        (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwritem (memwritem),
    .memtoregm (memtoregm),
    .aluoutm   (aluoutm),
    .writedatam(writedatam),
    .readdatam (readdatam),
    .stallm    (stallm),
    .misalignm (misalignm),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle_in();
    memwritem  = 1'b0;
    memtoregm  = 1'b0;
    aluoutm    = '0;
    writedatam = '0;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    idle_in();

    // reset state
    nxt(); nxt(); #1;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_stall", 32'(stallm), 0);
    chk("rst_rdata", readdatam, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_mis", 32'(misalignm), 0);
    chk("rst_berr", 32'(bus_err), 0);
    nxt(); reset = 1'b0;

    // load 0x100, ack with the request
    nxt(); memtoregm = 1'b1; aluoutm = 32'h100; #1;
    chk("ld_c0_stall", 32'(stallm), 1);
    chk("ld_c0_req", 32'(mem_req), 0);
    nxt(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("ld_c1_stall", 32'(stallm), 1);
    chk("ld_c1_req", 32'(mem_req), 1);
    chk("ld_c1_we", 32'(mem_we), 0);
    chk("ld_c1_addr", 32'(mem_addr), 32'h40);
    nxt(); mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("ld_c2_stall", 32'(stallm), 0);
    chk("ld_c2_req", 32'(mem_req), 0);
    chk("ld_c2_rdata", readdatam, 32'hDEADBEEF);
    idle_in();
    nxt(); #1;
    chk("ld_c3_stall", 32'(stallm), 0);
    chk("ld_c3_req", 32'(mem_req), 0);

    // store 0x200, ack after 3 wait cycles
    nxt(); memwritem = 1'b1; aluoutm = 32'h200;
    writedatam = 32'h12345678; #1;
    chk("st_c0_stall", 32'(stallm), 1);
    for (int i = 1; i <= 3; i++) begin
      nxt(); #1;
      chk("st_w_stall", 32'(stallm), 1);
      chk("st_w_req", 32'(mem_req), 1);
      chk("st_w_we", 32'(mem_we), 1);
      chk("st_w_addr", 32'(mem_addr), 32'h80);
      chk("st_w_wdata", mem_wdata, 32'h12345678);
    end
    nxt(); mem_ack = 1'b1; mem_rdata = 32'h55555555; #1;
    chk("st_c4_stall", 32'(stallm), 1);
    chk("st_c4_req", 32'(mem_req), 1);
    nxt(); mem_ack = 1'b0; #1;
    chk("st_c5_stall", 32'(stallm), 0);
    chk("st_c5_req", 32'(mem_req), 0);
    chk("st_c5_rdata", readdatam, 32'hDEADBEEF);
    chk("st_c5_berr", 32'(bus_err), 0);
    idle_in();

    // misaligned load 0x102
    nxt(); memtoregm = 1'b1; aluoutm = 32'h102; #1;
    chk("mis_c0_stall", 32'(stallm), 1);
    chk("mis_c0_mis", 32'(misalignm), 0);
    nxt(); #1;
    chk("mis_c1_stall", 32'(stallm), 0);
    chk("mis_c1_mis", 32'(misalignm), 1);
    chk("mis_c1_req", 32'(mem_req), 0);
    idle_in();
    nxt(); #1;
    chk("mis_c2_mis", 32'(misalignm), 0);
    chk("mis_c2_rdata", readdatam, 32'hDEADBEEF);

    // back-to-back load then store
    nxt(); memtoregm = 1'b1; aluoutm = 32'h300; #1;
    chk("bb_c0_stall", 32'(stallm), 1);
    nxt(); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    chk("bb_c1_req", 32'(mem_req), 1);
    nxt(); mem_ack = 1'b0; #1;
    chk("bb_c2_stall", 32'(stallm), 0);
    chk("bb_c2_rdata", readdatam, 32'hCAFEF00D);
    memtoregm = 1'b0; memwritem = 1'b1;
    aluoutm = 32'h304; writedatam = 32'hA5A5A5A5;
    nxt(); #1;
    chk("bb_c3_stall", 32'(stallm), 1);
    chk("bb_c3_req", 32'(mem_req), 0);
    nxt(); mem_ack = 1'b1; #1;
    chk("bb_c4_req", 32'(mem_req), 1);
    chk("bb_c4_we", 32'(mem_we), 1);
    chk("bb_c4_addr", 32'(mem_addr), 32'hC1);
    chk("bb_c4_wdata", mem_wdata, 32'hA5A5A5A5);
    nxt(); mem_ack = 1'b0; #1;
    chk("bb_c5_stall", 32'(stallm), 0);
    chk("bb_c5_req", 32'(mem_req), 0);
    chk("bb_c5_rdata", readdatam, 32'hCAFEF00D);
    idle_in();

    // reset in the middle of BUSY
    nxt(); memtoregm = 1'b1; aluoutm = 32'h400; #1;
    nxt(); #1;
    chk("rb_busy_req", 32'(mem_req), 1);
    #2 reset = 1'b1; #1;
    chk("rb_async_req", 32'(mem_req), 0);
    chk("rb_async_rdata", readdatam, 0);
    nxt(); reset = 1'b0; idle_in();
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    for (int i = 0; i < 2; i++) begin
      nxt(); #1;
      chk("rb_stray_req", 32'(mem_req), 0);
      chk("rb_stray_stall", 32'(stallm), 0);
      chk("rb_stray_rdata", readdatam, 0);
    end
    mem_ack = 1'b0;

`ifdef DMEM_TIMEOUT_EN
    // preload nonzero data, then a load that times out
    nxt(); memtoregm = 1'b1; aluoutm = 32'h500; #1;
    nxt(); mem_ack = 1'b1; mem_rdata = 32'h11111111; #1;
    nxt(); mem_ack = 1'b0; #1;
    chk("to_pre_rdata", readdatam, 32'h11111111);
    aluoutm = 32'h504;
    nxt(); #1;
    chk("to_c0_stall", 32'(stallm), 1);
    for (int i = 1; i <= 4; i++) begin
      nxt(); #1;
      chk("to_w_req", 32'(mem_req), 1);
      chk("to_w_berr", 32'(bus_err), 0);
      chk("to_w_stall", 32'(stallm), 1);
    end
    nxt(); #1;
    chk("to_c5_berr", 32'(bus_err), 1);
    chk("to_c5_req", 32'(mem_req), 0);
    chk("to_c5_stall", 32'(stallm), 0);
    chk("to_c5_rdata", readdatam, 0);
    idle_in();
    nxt(); #1;
    chk("to_c6_berr", 32'(bus_err), 0);
`endif

    nxt();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
